// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding, PID and framing constants for the USB TX sequencer.
// Optional feature macro used by the sequencer: USB_TX_UNDERRUN_ABORT_EN.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRCL,
        CRCH,
        EOP,
        DONE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         EOP_BITS  = 3;

    localparam logic [3:0] ACK   = 4'b0010;
    localparam logic [3:0] NAK   = 4'b1010;
    localparam logic [3:0] STALL = 4'b1110;
    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == 2'b11;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_sequencer_bytecnt.sv
// usb_tx_bytecnt: loadable down-counter of payload bytes still to be loaded.
// Saturates at zero; zero flag tells the sequencer the payload is exhausted.
module usb_tx_bytecnt #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    assign zero = (count == '0);

    // load at packet start, step down once per payload byte loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: paces SYNC, PID, payload, CRC16 and EOP on the bit timer strobes.
// Define USB_TX_UNDERRUN_ABORT_EN to abort to EOP on FIFO underrun instead of padding 00.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter  int MAXPKT = 64,
    localparam int CW     = $clog2(MAXPKT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_start,
    input  logic [3:0]    tx_pid,
    input  logic [CW-1:0] tx_len,
    input  logic          fifo_empty,
    input  logic [7:0]    fifo_rdata,
    output logic          fifo_rd,
    input  logic          clk12,
    input  logic          bytecomplete,
    input  logic [15:0]   crc_in,
    output logic          timer_en,
    output logic          load_byte,
    output logic [7:0]    tx_byte,
    output logic          crc_clear,
    output logic          crc_en,
    output logic          eop_en,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          tx_error
);

    localparam logic [1:0] EOP_LAST = 2'(EOP_BITS - 1);

    state_t      state, nxt;
    logic [3:0]  pid_q;
    logic [1:0]  eop_cnt;
    logic [CW-1:0] remaining;
    logic        cnt_zero, cnt_load, cnt_dec;
    logic        boundary, data_step, pop;
    logic        ld_n, clr_n, crcen_n;
    logic [7:0]  byte_n;
`ifdef USB_TX_UNDERRUN_ABORT_EN
    logic        err_n, err_q;
`endif

    usb_tx_bytecnt #(.CW(CW)) u_bytecnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (tx_len),
        .dec      (cnt_dec),
        .count    (remaining),
        .zero     (cnt_zero)
    );

    assign boundary = timer_en && clk12 && bytecomplete;
    assign timer_en = (state != IDLE) && (state != DONE);
    assign tx_busy  = (state != IDLE);
    assign eop_en   = (state == EOP);
    assign tx_done  = (state == DONE);
    assign fifo_rd  = pop && !rst;
`ifdef USB_TX_UNDERRUN_ABORT_EN
    assign tx_error = err_q;
`else
    assign tx_error = 1'b0;
`endif

    // next state and the byte/CRC controls to register for the next cycle
    always_comb begin
        nxt       = state;
        ld_n      = 1'b0;
        byte_n    = 8'h00;
        clr_n     = 1'b0;
        crcen_n   = 1'b0;
        pop       = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        data_step = 1'b0;
`ifdef USB_TX_UNDERRUN_ABORT_EN
        err_n     = 1'b0;
`endif
        unique case (state)
            IDLE: if (tx_start) begin
                nxt      = SYNC;
                ld_n     = 1'b1;
                byte_n   = SYNC_BYTE;
                clr_n    = 1'b1;
                cnt_load = 1'b1;
            end
            SYNC: if (boundary) begin
                nxt    = PID;
                ld_n   = 1'b1;
                byte_n = pid_byte(pid_q);
            end
            PID: if (boundary) begin
                if (!is_data_pid(pid_q)) begin
                    nxt = EOP;
                end else if (cnt_zero) begin
                    nxt    = CRCL;
                    ld_n   = 1'b1;
                    byte_n = crc_in[7:0];
                end else begin
                    data_step = 1'b1;
                end
            end
            DATA: if (boundary) begin
                if (cnt_zero) begin
                    nxt    = CRCL;
                    ld_n   = 1'b1;
                    byte_n = crc_in[7:0];
                end else begin
                    data_step = 1'b1;
                end
            end
            CRCL: if (boundary) begin
                nxt    = CRCH;
                ld_n   = 1'b1;
                byte_n = crc_in[15:8];
            end
            CRCH: if (boundary) nxt = EOP;
            EOP:  if (clk12 && eop_cnt == EOP_LAST) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase

        if (data_step) begin
`ifdef USB_TX_UNDERRUN_ABORT_EN
            if (fifo_empty) begin
                nxt   = EOP;
                err_n = 1'b1;
            end else begin
                nxt     = DATA;
                ld_n    = 1'b1;
                byte_n  = fifo_rdata;
                crcen_n = 1'b1;
                pop     = 1'b1;
                cnt_dec = 1'b1;
            end
`else
            nxt     = DATA;
            ld_n    = 1'b1;
            byte_n  = fifo_empty ? 8'h00 : fifo_rdata;
            crcen_n = 1'b1;
            pop     = !fifo_empty;
            cnt_dec = 1'b1;
`endif
        end
    end

    // state, captured PID, EOP bit counter and registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pid_q     <= 4'h0;
            eop_cnt   <= 2'd0;
            load_byte <= 1'b0;
            tx_byte   <= 8'h00;
            crc_clear <= 1'b0;
            crc_en    <= 1'b0;
`ifdef USB_TX_UNDERRUN_ABORT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= nxt;
            load_byte <= ld_n;
            crc_clear <= clr_n;
            crc_en    <= crcen_n;
`ifdef USB_TX_UNDERRUN_ABORT_EN
            err_q     <= err_n;
`endif
            if (ld_n) tx_byte <= byte_n;
            if (state == IDLE && tx_start) pid_q <= tx_pid;
            if (state != EOP) eop_cnt <= 2'd0;
            else if (clk12) eop_cnt <= eop_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb_usb_tx_sequencer: directed packets against a bench bit-timer and FIFO model.
// Honours USB_TX_UNDERRUN_ABORT_EN to pick the expected underrun behaviour.
module tb_usb_tx_sequencer;
    import usb_tx_pkg::*;

    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [3:0]    tx_pid;
    logic [CW-1:0] tx_len;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic          fifo_rd;
    logic          clk12;
    logic          bytecomplete;
    logic [15:0]   crc_in;
    logic          timer_en, load_byte, crc_clear, crc_en;
    logic          eop_en, tx_busy, tx_done, tx_error;
    logic [7:0]    tx_byte;

    int checks = 0;
    int failures = 0;

    logic [7:0] got[$];
    logic [7:0] expq[$];
    logic [7:0] fifo_q[$];
    int fifo_idx;
    int n_rd, n_crc, n_clr, n_err, n_done, n_eop, bad_ld, bad_done, timeout;

    always #5 clk = ~clk;

    usb_tx_sequencer #(.MAXPKT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_pid       (tx_pid),
        .tx_len       (tx_len),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_rd      (fifo_rd),
        .clk12        (clk12),
        .bytecomplete (bytecomplete),
        .crc_in       (crc_in),
        .timer_en     (timer_en),
        .load_byte    (load_byte),
        .tx_byte      (tx_byte),
        .crc_clear    (crc_clear),
        .crc_en       (crc_en),
        .eop_en       (eop_en),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one packet with a modelled bit timer; stop_at>0 returns early
    // once that many byte loads have been seen.
    task automatic run_pkt(input logic [3:0] pid, input logic [CW-1:0] len,
                           input bit rnd, input int stop_at);
        int gap;
        int bits;
        bit pb;
        bit fin;
        got.delete();
        n_rd = 0; n_crc = 0; n_clr = 0; n_err = 0; n_done = 0; n_eop = 0;
        bad_ld = 0; bad_done = 0; timeout = 1;
        fifo_idx = 0;
        tx_pid = pid;
        tx_len = len;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        pb = 1'b1;
        gap = 0;
        bits = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (load_byte) begin
                if (!pb) bad_ld++;
                got.push_back(tx_byte);
            end
            if (crc_clear) n_clr++;
            if (crc_en) n_crc++;
            if (tx_error) n_err++;
            if (tx_done) begin
                n_done++;
                if (timer_en || eop_en || !tx_busy) bad_done++;
                fin = 1'b1;
            end
            if (stop_at > 0 && got.size() >= stop_at) fin = 1'b1;
            if (fin) begin
                timeout = 0;
                clk12 = 1'b0;
                bytecomplete = 1'b0;
                break;
            end
            if (timer_en) begin
                if (gap == 0) begin
                    clk12 = 1'b1;
                    bytecomplete = (bits == 7);
                    bits = (bits + 1) % 8;
                    gap = rnd ? int'($urandom_range(1, 4)) : 1;
                end else begin
                    clk12 = 1'b0;
                    bytecomplete = 1'b0;
                    gap--;
                end
            end else begin
                clk12 = 1'b0;
                bytecomplete = 1'b0;
                bits = 0;
                gap = 0;
            end
            if (eop_en && clk12) n_eop++;
            pb = clk12 && bytecomplete;
            fifo_empty = (fifo_idx >= fifo_q.size());
            fifo_rdata = fifo_empty ? 8'h00 : fifo_q[fifo_idx];
            #1;
            if (fifo_rd) begin
                n_rd++;
                if (!fifo_empty) fifo_idx++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_pkt(input string tag, input int rd, input int crc,
                             input int err);
        chk({tag, ".timeout"}, timeout, 0);
        chk({tag, ".nload"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s.byte%0d", tag, i), got[i], expq[i]);
        chk({tag, ".fifo_rd"}, n_rd, rd);
        chk({tag, ".crc_en"}, n_crc, crc);
        chk({tag, ".crc_clear"}, n_clr, 1);
        chk({tag, ".tx_error"}, n_err, err);
        chk({tag, ".tx_done"}, n_done, 1);
        chk({tag, ".eop_bits"}, n_eop, 3);
        chk({tag, ".load_timing"}, bad_ld, 0);
        chk({tag, ".done_cycle"}, bad_done, 0);
        @(posedge clk); #1;
        chk({tag, ".busy_after"}, tx_busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        tx_start = 1'b0;
        tx_pid = 4'h0;
        tx_len = '0;
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;
        clk12 = 1'b0;
        bytecomplete = 1'b0;
        crc_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outs",
            {timer_en, load_byte, tx_byte, crc_clear, crc_en,
             eop_en, tx_busy, tx_done, tx_error, fifo_rd}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ACK handshake
        fifo_q = {};
        crc_in = 16'h1234;
        expq = '{8'h80, 8'hD2};
        run_pkt(ACK, 7'd5, 1'b0, 0);
        check_pkt("ack", 0, 0, 0);

        // DATA0 with three payload bytes
        fifo_q = '{8'h11, 8'h22, 8'h33};
        crc_in = 16'hBEEF;
        expq = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hEF, 8'hBE};
        run_pkt(DATA0, 7'd3, 1'b0, 0);
        check_pkt("data0", 3, 3, 0);

        // zero-length DATA1
        fifo_q = {};
        crc_in = 16'h0000;
        expq = '{8'h80, 8'h4B, 8'h00, 8'h00};
        run_pkt(DATA1, 7'd0, 1'b0, 0);
        check_pkt("data1_zlp", 0, 0, 0);

        // random bit-stuff gaps between strobes
        fifo_q = '{8'hDE, 8'hAD, 8'hBE};
        crc_in = 16'hA55A;
        expq = '{8'h80, 8'h4B, 8'hDE, 8'hAD, 8'hBE, 8'h5A, 8'hA5};
        run_pkt(DATA1, 7'd3, 1'b1, 0);
        check_pkt("stuff_gaps", 3, 3, 0);

        // underrun after the first of four bytes
        fifo_q = '{8'hAA};
        crc_in = 16'h7E81;
`ifdef USB_TX_UNDERRUN_ABORT_EN
        expq = '{8'h80, 8'hC3, 8'hAA};
        run_pkt(DATA0, 7'd4, 1'b0, 0);
        check_pkt("underrun", 1, 1, 1);
`else
        expq = '{8'h80, 8'hC3, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h81, 8'h7E};
        run_pkt(DATA0, 7'd4, 1'b0, 0);
        check_pkt("underrun", 1, 4, 0);
`endif

        // reset in the middle of the DATA state, on a boundary cycle
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        crc_in = 16'h0F0F;
        run_pkt(DATA0, 7'd4, 1'b0, 4);
        chk("rst.pre_timeout", timeout, 0);
        chk("rst.pre_busy", tx_busy, 1);
        fifo_empty = 1'b0;
        fifo_rdata = fifo_q[fifo_idx];
        clk12 = 1'b1;
        bytecomplete = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst.no_pop", fifo_rd, 0);
        @(posedge clk); #1;
        chk("rst.outs",
            {timer_en, load_byte, tx_byte, crc_clear, crc_en,
             eop_en, tx_busy, tx_done, tx_error, fifo_rd}, 0);
        rst = 1'b0;
        clk12 = 1'b0;
        bytecomplete = 1'b0;
        fifo_empty = 1'b1;
        @(posedge clk); #1;
        chk("rst.idle_after", {tx_busy, tx_done, load_byte}, 0);

        // full packet after the reset
        fifo_q = '{8'h5A, 8'hA5};
        crc_in = 16'hC001;
        expq = '{8'h80, 8'hC3, 8'h5A, 8'hA5, 8'h01, 8'hC0};
        run_pkt(DATA0, 7'd2, 1'b1, 0);
        check_pkt("post_rst", 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Packet-level controller for the USB TX path. It sequences one transmit packet: SYNC, PID, optional payload, optional CRC16 and EOP. It drives the bit timer enable and the byte-load, CRC and EOP controls, pacing itself on the timer's 12 MHz bit strobe and byte-complete strobes. It sits between the endpoint's TX FIFO and control logic and the TX shift/encode datapath.

## Interface
- MAXPKT, default 64: maximum payload bytes. Byte-count width is $clog2(MAXPKT+1).
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- tx_start, input, 1: start request. Sampled only in IDLE.
- tx_pid, input, 4: PID nibble, captured at start.
- tx_len, input, CW: payload byte count, captured at start. Ignored for handshake PIDs.
- fifo_empty, input, 1: TX FIFO empty.
- fifo_rdata, input, 8: FIFO show-ahead data. Valid when !fifo_empty.
- fifo_rd, output, 1: FIFO pop. Combinational.
- clk12, input, 1: bit-time strobe from the bit timer.
- bytecomplete, input, 1: byte-done flag from the bit timer.
- crc_in, input, 16: running CRC16 from the CRC block, already complemented.
- timer_en, output, 1: bit timer enable.
- load_byte, output, 1: one-cycle pulse to load tx_byte into the shifter.
- tx_byte, output, 8: byte to shift, sent LSB first.
- crc_clear, output, 1: initialise the CRC.
- crc_en, output, 1: fold the loaded byte into the CRC.
- eop_en, output, 1: drive SE0/J end-of-packet.
- tx_busy, output, 1: high in every state except IDLE.
- tx_done, output, 1: one-cycle completion pulse.
- tx_error, output, 1: one-cycle underrun pulse (see Configuration).

## Operation
- All outputs reset to 0. The state resets to IDLE.
- boundary = clk12 && bytecomplete, evaluated only while timer_en=1.
- Packet type:
  - tx_pid[1:0]==2'b11 is a DATA packet (DATA0/DATA1).
  - Any other PID is a handshake (ACK, NAK, STALL) with no payload and no CRC.
- States and transitions:
  - IDLE: on tx_start, capture tx_pid and tx_len, go to SYNC.
  - SYNC: on boundary, go to PID.
  - PID: on boundary, go to DATA if DATA packet and len>0; CRCL if DATA packet and len==0; EOP if handshake.
  - DATA: on boundary, decrement remaining; at 0, go to CRCL.
  - CRCL: on boundary, go to CRCH.
  - CRCH: on boundary, go to EOP.
  - EOP: count 3 clk12 strobes (2 SE0 bit times, then 1 J bit time), then go to DONE.
  - DONE: for one cycle, go to IDLE.
- Byte loaded on entry to each state:
  - SYNC: 8'h80. crc_clear=1 on this load.
  - PID: {~pid, pid}.
  - DATA: fifo_rdata, with crc_en=1.
  - CRCL: crc_in[7:0].
  - CRCH: crc_in[15:8].
- fifo_rd=1 exactly when the state is PID or DATA, a boundary occurs, the next state is DATA, and !fifo_empty.
- Zero-length DATA packet: PID is followed directly by the CRC bytes from crc_in, which is 16'h0000 after clear.
- A tx_start outside IDLE is ignored.
- Bit-stuff stalls are absorbed inside the timer. The sequencer only reacts to strobes.

## Timing
- tx_start high in IDLE at edge N:
  - At N+1, state=SYNC, timer_en=1, load_byte=1, tx_byte=8'h80, crc_clear=1, tx_busy=1.
- Boundary at edge M:
  - At M+1, the next byte appears with a one-cycle load_byte pulse.
  - fifo_rd is high in cycle M, and the popped byte is tx_byte at M+1.
- load_byte, crc_clear, crc_en and tx_done are single-cycle pulses.
- eop_en is held high for the whole EOP state. timer_en stays high through EOP.
- DONE cycle: tx_done=1, timer_en=0, eop_en=0. tx_busy drops the following cycle.
- A boundary in DATA with remaining==1 is the last pop, then CRCL.
- rst asserted at any edge (including mid-packet or in EOP):
  - Next cycle, IDLE with all outputs 0.
  - No tx_done and no fifo_rd are issued.

## Configuration
- USB_TX_UNDERRUN_ABORT_EN defined:
  - A DATA-bound boundary with fifo_empty=1 gives: tx_error=1 for one cycle, no fifo_rd, and a jump straight to EOP with no CRC sent.
  - The packet then completes with tx_done.
- Macro undefined:
  - tx_error is tied to 0.
  - On underrun, tx_byte=8'h00 is loaded, crc_en=1 and there is no pop. The sequence continues normally.

## Structure
- Package usb_tx_pkg holds:
  - The state enum: IDLE, SYNC, PID, DATA, CRCL, CRCH, EOP, DONE.
  - Constants SYNC_BYTE=8'h80 and EOP_BITS=3.
  - PID constants: ACK=4'b0010, NAK=4'b1010, STALL=4'b1110, DATA0=4'b0011, DATA1=4'b1011.
- Sub-module usb_tx_bytecnt: loadable down-counter of remaining payload bytes, with a zero flag.

## Test plan
- ACK (tx_pid=4'b0010):
  - Bytes loaded: 80, D2, then EOP.
  - Exactly 3 clk12 strobes in EOP.
  - tx_done one cycle. 0 fifo_rd. No crc_en.
- DATA0 with tx_len=3 and FIFO {11,22,33}:
  - Bytes loaded: 80, C3, 11, 22, 33, crc_in[7:0], crc_in[15:8].
  - 3 fifo_rd pulses and 3 crc_en pulses.
- DATA1 with tx_len=0:
  - Bytes loaded: 80, 4B, 00, 00, then EOP.
- Timer strobes with random bit-stuff gaps:
  - Load count and order unchanged.
  - Loads occur only at boundary+1.
- FIFO emptied after 1 of 4 bytes:
  - With the macro: tx_error pulse, then EOP, then tx_done.
  - Without the macro: 00 bytes substituted and both CRC bytes still sent.
- rst pulsed in the DATA state:
  - Next cycle all outputs 0 and state IDLE.
  - A following tx_start runs a full packet normally.
